// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-processing blocks: sample layout, magnitude width,
// summary flag positions and the peak-detector FSM encoding.
package pulse_pkg;
    localparam int DATA_W        = 32;
    localparam int I_MSB         = 31;
    localparam int Q_MSB         = 15;
    localparam int MAG_W         = 17;
    localparam int LEN_ERR_BIT   = 31;
    localparam int ABOVE_THR_BIT = 30;

    typedef enum logic [1:0] {
        ST_PASS = 2'd0,
        ST_SUM0 = 2'd1,
        ST_SUM1 = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] sum0_word(input logic       len_err,
                                                    input logic       above_thr,
                                                    input logic [15:0] peak_idx);
        logic [DATA_W-1:0] w;
        w                = '0;
        w[LEN_ERR_BIT]   = len_err;
        w[ABOVE_THR_BIT] = above_thr;
        w[15:0]          = peak_idx;
        return w;
    endfunction
endpackage

// File: rtl/pulse_mag_abs.sv
// Magnitude proxy |I| + |Q| of one packed I/Q sample; purely combinational.
// 17-bit result so the -32768 corners (65536 total) cannot overflow.
module pulse_mag_abs
    import pulse_pkg::*;
(
    input  logic [DATA_W-1:0] i_sample,
    output logic [MAG_W-1:0]  o_mag
);
    logic [MAG_W-1:0] w_i;
    logic [MAG_W-1:0] w_q;
    logic [MAG_W-1:0] w_abs_i;
    logic [MAG_W-1:0] w_abs_q;

    assign w_i     = {i_sample[I_MSB], i_sample[I_MSB -: 16]};
    assign w_q     = {i_sample[Q_MSB], i_sample[Q_MSB -: 16]};
    assign w_abs_i = w_i[MAG_W-1] ? (~w_i + 17'd1) : w_i;
    assign w_abs_q = w_q[MAG_W-1] ? (~w_q + 17'd1) : w_q;
    assign o_mag   = w_abs_i + w_abs_q;
endmodule

// File: rtl/pulse_cir_peak.sv
// Forwards CIR frames unchanged and appends {flags, peak_idx} and {peak_mag} summary words.
// One registered output stage (1-cycle latency); input is held off while the summary drains.
module pulse_cir_peak
    import pulse_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] i_data_TDATA,
    input  logic              i_data_TVALID,
    output logic              i_data_TREADY,
    input  logic              i_data_TLAST,
    output logic [DATA_W-1:0] o_data_TDATA,
    output logic              o_data_TVALID,
    input  logic              o_data_TREADY,
    output logic              o_data_TLAST,
    input  logic [15:0]       seq_len_V,
    input  logic [MAG_W-1:0]  peak_thresh_V
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_run;
    logic [DATA_W-1:0]  r_o_dat;
    logic               r_o_vld;
    logic               r_o_last;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_peak_idx;
    logic [MAG_W-1:0]   r_peak_mag;
    logic [MAG_W-1:0]   r_thr;
    logic [15:0]        r_seq_len;
    logic               r_len_err;

    logic [MAG_W-1:0]   w_mag;
    logic               w_o_free;
    logic               w_in_rdy;
    logic               w_in_acc;
    logic               w_first;
    logic               w_new_peak;
    logic [15:0]        w_seq_eff;
    logic [IDX_W:0]     w_cnt;
    logic               w_len_err;

    pulse_mag_abs u_mag (
        .i_sample (i_data_TDATA),
        .o_mag    (w_mag)
    );

    assign w_o_free   = !r_o_vld || o_data_TREADY;
    assign w_in_rdy   = r_run && (r_state == ST_PASS) && w_o_free;
    assign w_in_acc   = i_data_TVALID && w_in_rdy;
    assign w_first    = (r_idx == '0);
    assign w_new_peak = w_first || (w_mag > r_peak_mag);
    // Settings are latched on the first sample, so that sample must see the live value.
    assign w_seq_eff  = w_first ? seq_len_V : r_seq_len;
    assign w_cnt      = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};
    assign w_len_err  = 32'(w_cnt) != 32'(w_seq_eff);

    // Each SUMx state lasts until its word can enter the output register; after
    // SUM1 the FSM is back in PASS while word 1 drains, keeping frame overhead at 2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_PASS: if (w_in_acc && i_data_TLAST) w_state_nxt = ST_SUM0;
            ST_SUM0: if (w_o_free) w_state_nxt = ST_SUM1;
            ST_SUM1: if (w_o_free) w_state_nxt = ST_PASS;
            default: w_state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state  <= ST_PASS;
            r_run    <= 1'b0;
            r_o_dat  <= '0;
            r_o_vld  <= 1'b0;
            r_o_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            case (r_state)
                ST_PASS: begin
                    if (w_in_acc) begin
                        r_o_dat  <= i_data_TDATA;
                        r_o_vld  <= 1'b1;
                        r_o_last <= 1'b0;
                    end else if (o_data_TREADY) begin
                        r_o_vld  <= 1'b0;
                        r_o_last <= 1'b0;
                    end
                end
                ST_SUM0: begin
                    if (w_o_free) begin
                        r_o_dat  <= sum0_word(r_len_err, r_peak_mag >= r_thr, 16'(r_peak_idx));
                        r_o_vld  <= 1'b1;
                        r_o_last <= 1'b0;
                    end
                end
                ST_SUM1: begin
                    if (w_o_free) begin
                        r_o_dat  <= {{(DATA_W-MAG_W){1'b0}}, r_peak_mag};
                        r_o_vld  <= 1'b1;
                        r_o_last <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_idx      <= '0;
            r_peak_idx <= '0;
            r_peak_mag <= '0;
            r_thr      <= '0;
            r_seq_len  <= '0;
            r_len_err  <= 1'b0;
        end else if (w_in_acc) begin
            if (r_idx != '1) r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
            if (w_new_peak) begin
                r_peak_mag <= w_mag;
                r_peak_idx <= r_idx;
            end
            if (w_first) begin
                r_seq_len <= seq_len_V;
                r_thr     <= peak_thresh_V;
            end
            if (i_data_TLAST) r_len_err <= w_len_err;
        end else if (r_state == ST_SUM1 && w_o_free) begin
            r_idx <= '0;
        end
    end

    assign i_data_TREADY = w_in_rdy;
    assign o_data_TDATA  = r_o_dat;
    assign o_data_TVALID = r_o_vld;
    assign o_data_TLAST  = r_o_last;
endmodule

// File: tb/tb_pulse_cir_peak.sv
// Directed and randomized-backpressure bench for pulse_cir_peak with a scoreboard of expected beats.
module tb_pulse_cir_peak;
    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] i_data_TDATA = '0;
    logic        i_data_TVALID = 1'b0;
    logic        i_data_TREADY;
    logic        i_data_TLAST = 1'b0;
    logic [31:0] o_data_TDATA;
    logic        o_data_TVALID;
    logic        o_data_TREADY = 1'b1;
    logic        o_data_TLAST;
    logic [15:0] seq_len_V = '0;
    logic [16:0] peak_thresh_V = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt = 0;

    logic [31:0] in_q[$];
    logic        in_last_q[$];
    logic [31:0] exp_dat[$];
    logic        exp_last[$];

    pulse_cir_peak #(.IDX_W(16)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .i_data_TDATA  (i_data_TDATA),
        .i_data_TVALID (i_data_TVALID),
        .i_data_TREADY (i_data_TREADY),
        .i_data_TLAST  (i_data_TLAST),
        .o_data_TDATA  (o_data_TDATA),
        .o_data_TVALID (o_data_TVALID),
        .o_data_TREADY (o_data_TREADY),
        .o_data_TLAST  (o_data_TLAST),
        .seq_len_V     (seq_len_V),
        .peak_thresh_V (peak_thresh_V)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input logic [31:0] s);
        logic signed [15:0] vi;
        logic signed [15:0] vq;
        int a;
        int b;
        vi = s[31:16];
        vq = s[15:0];
        a = int'(vi);
        b = int'(vq);
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return a + b;
    endfunction

    task automatic push_in(input logic [31:0] s, input logic last);
        in_q.push_back(s);
        in_last_q.push_back(last);
        exp_dat.push_back(s);
        exp_last.push_back(1'b0);
    endtask

    task automatic push_sum(input logic [31:0] w0, input logic [31:0] w1);
        exp_dat.push_back(w0);
        exp_last.push_back(1'b0);
        exp_dat.push_back(w1);
        exp_last.push_back(1'b1);
    endtask

    task automatic gen_frame(input int len, input logic [15:0] seq, input logic [16:0] thr);
        logic [31:0] s;
        logic [31:0] w0;
        int m;
        int pk_mag;
        int pk_idx;
        pk_mag = 0;
        pk_idx = 0;
        for (int i = 0; i < len; i++) begin
            s = $urandom;
            if ($urandom_range(0, 7) == 0) s = 32'h8000_8000;
            m = mag_of(s);
            if (i == 0 || m > pk_mag) begin
                pk_mag = m;
                pk_idx = i;
            end
            push_in(s, i == len - 1);
        end
        w0 = '0;
        w0[31] = (len != int'(seq));
        w0[30] = (pk_mag >= int'(thr));
        w0[15:0] = 16'(pk_idx);
        push_sum(w0, 32'(pk_mag));
    endtask

    task automatic run_frames(input int max_cyc, input bit rand_rdy, input int chg_after,
                              input logic [15:0] chg_seq, input logic [16:0] chg_thr);
        int cyc;
        int acc;
        bit prev_stall;
        logic [31:0] prev_dat;
        logic prev_last;
        cyc = 0;
        acc = 0;
        prev_stall = 0;
        prev_dat = '0;
        prev_last = 1'b0;
        while ((in_q.size() > 0 || exp_dat.size() > 0) && cyc < max_cyc) begin
            @(negedge ap_clk);
            o_data_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_q.size() > 0) begin
                i_data_TVALID = 1'b1;
                i_data_TDATA  = in_q[0];
                i_data_TLAST  = in_last_q[0];
            end else begin
                i_data_TVALID = 1'b0;
                i_data_TDATA  = '0;
                i_data_TLAST  = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check_val("stable_vld", o_data_TVALID, 1);
                check_val("stable_dat", o_data_TDATA, prev_dat);
                check_val("stable_last", o_data_TLAST, prev_last);
            end
            prev_stall = o_data_TVALID && !o_data_TREADY;
            prev_dat   = o_data_TDATA;
            prev_last  = o_data_TLAST;
            if (i_data_TVALID && !i_data_TREADY) stall_cnt++;
            if (i_data_TVALID && i_data_TREADY) begin
                void'(in_q.pop_front());
                void'(in_last_q.pop_front());
                acc++;
                if (acc == chg_after) begin
                    seq_len_V     = chg_seq;
                    peak_thresh_V = chg_thr;
                end
            end
            if (o_data_TVALID && o_data_TREADY) begin
                if (exp_dat.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    check_val("out_dat", o_data_TDATA, exp_dat.pop_front());
                    check_val("out_last", o_data_TLAST, exp_last.pop_front());
                end
            end
            cyc++;
        end
        if (in_q.size() > 0 || exp_dat.size() > 0) begin
            check_val("timeout", 1, 0);
            in_q.delete();
            in_last_q.delete();
            exp_dat.delete();
            exp_last.delete();
        end
        @(negedge ap_clk);
        i_data_TVALID = 1'b0;
        i_data_TLAST  = 1'b0;
        o_data_TREADY = 1'b1;
    endtask

    logic [31:0] t1 [8] = '{32'h0001_0002, 32'h0003_FFFE, 32'hFFFB_0005, 32'h0000_0000,
                            32'h0002_0002, 32'h0040_FFC0, 32'hFFFF_FFFF, 32'h0005_0000};
    logic [31:0] rst_s [3] = '{32'h0100_0000, 32'h0001_0001, 32'h0002_0002};

    initial begin
        // Reset values while held in reset
        #12;
        check_val("rst_vld", o_data_TVALID, 0);
        check_val("rst_last", o_data_TLAST, 0);
        check_val("rst_dat", o_data_TDATA, 0);
        check_val("rst_in_rdy", i_data_TREADY, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        #1;
        check_val("post_rst_rdy", i_data_TREADY, 1);

        // 8-sample frame with isolated peak, then a 1-sample frame with the same settings
        seq_len_V = 16'd8;
        peak_thresh_V = 17'd100;
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) push_in(t1[i], i == 7);
        push_sum(32'h4000_0005, 32'h0000_0080);
        push_in(32'h0000_0003, 1'b1);
        push_sum(32'h8000_0000, 32'h0000_0003);
        run_frames(200, 0, -1, 16'd0, 17'd0);
        check_val("stall_cycles", 32'(stall_cnt), 2);

        // Tie at mag 500 keeps the earliest index
        seq_len_V = 16'd8;
        peak_thresh_V = 17'd400;
        for (int i = 0; i < 8; i++)
            push_in(i == 2 ? 32'h0100_FF0C : (i == 6 ? 32'h01F4_0000 : 32'h0010_0010), i == 7);
        push_sum(32'h4000_0002, 32'h0000_01F4);
        run_frames(200, 0, -1, 16'd0, 17'd0);

        // Short frame below threshold; mid-frame setting change must be ignored
        seq_len_V = 16'd16;
        peak_thresh_V = 17'd60;
        for (int i = 0; i < 12; i++) push_in(i == 7 ? 32'h0019_FFE7 : 32'h0001_0001, i == 11);
        push_sum(32'h8000_0007, 32'h0000_0032);
        run_frames(200, 0, 4, 16'd12, 17'd10);

        // Extreme magnitude, one-sample frame, threshold equal to magnitude
        seq_len_V = 16'd1;
        peak_thresh_V = 17'h1_0000;
        push_in(32'h8000_8000, 1'b1);
        push_sum(32'h4000_0000, 32'h0001_0000);
        run_frames(50, 0, -1, 16'd0, 17'd0);

        // seq_len of zero always flags a length error
        seq_len_V = 16'd0;
        peak_thresh_V = 17'h1_FFFF;
        push_in(32'h7FFF_7FFF, 1'b1);
        push_sum(32'h8000_0000, 32'h0000_FFFE);
        run_frames(50, 0, -1, 16'd0, 17'd0);

        // Random frames under random output backpressure
        for (int f = 0; f < 100; f++) begin
            int len;
            len = $urandom_range(1, 64);
            seq_len_V = ($urandom_range(0, 1) == 0) ? 16'(len) : 16'($urandom_range(0, 70));
            peak_thresh_V = 17'($urandom_range(0, 70000));
            gen_frame(len, seq_len_V, peak_thresh_V);
            run_frames(2000, 1, -1, 16'd0, 17'd0);
        end

        // Reset asserted while the summary is pending
        seq_len_V = 16'd3;
        peak_thresh_V = 17'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            i_data_TVALID = 1'b1;
            i_data_TDATA  = rst_s[k];
            i_data_TLAST  = (k == 2);
            #1;
            check_val("rstmid_in_rdy", i_data_TREADY, 1);
        end
        @(negedge ap_clk);
        i_data_TVALID = 1'b0;
        i_data_TLAST  = 1'b0;
        #1;
        check_val("sum0_out_vld", o_data_TVALID, 1);
        check_val("sum0_in_rdy", i_data_TREADY, 0);
        ap_rst_n = 1'b0;
        #1;
        check_val("rstmid_vld", o_data_TVALID, 0);
        check_val("rstmid_last", o_data_TLAST, 0);
        check_val("rstmid_dat", o_data_TDATA, 0);
        check_val("rstmid_in_rdy0", i_data_TREADY, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        seq_len_V = 16'd2;
        peak_thresh_V = 17'd100;
        push_in(32'h0001_0001, 1'b0);
        push_in(32'h0000_0064, 1'b1);
        push_sum(32'h4000_0001, 32'h0000_0064);
        run_frames(100, 0, -1, 16'd0, 17'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
